// File: rtl/processor_16b.sv
// Single-cycle 16-bit load/store processor: instruction ROM, 8x16 register file,
// 16-bit ALU and data RAM, retiring one instruction per rising clock edge.
module processor_16b #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_INIT  = "program.mem"
) (
  input logic clk,
  input logic reset
);

  typedef enum logic [3:0] {
    OpRtype = 4'h0,
    OpAddi  = 4'h1,
    OpLw    = 4'h2,
    OpSw    = 4'h3,
    OpBeq   = 4'h4,
    OpBne   = 4'h5,
    OpJmp   = 4'h6,
    OpAndi  = 4'h7
  } opcode_e;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSlt = 3'd7
  } alu_op_e;

  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];
  logic [15:0] rf_q [8];

  logic [15:0] pc_current;
  logic [15:0] pc_next;
  logic [15:0] pc_plus1;
  logic [15:0] instruction;
  opcode_e     opcode;
  logic [2:0]  src;
  logic [2:0]  dest;
  logic [5:0]  imm_or_fn;
  logic [15:0] sign_ext_imm;
  logic [15:0] branch_offset;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] mem_read_data;
  logic        alu_src;
  logic [15:0] alu_src_mux_out;
  alu_op_e     alu_op;
  logic [15:0] alu_result;
  logic        reg_write;
  logic        mem_write;

  // Unloaded ROM words read as 0x0000, which behaves as a NOP (ADD into R0).
  initial begin
    for (int i = 0; i < int'(IMEM_DEPTH); i++) imem[i] = '0;
  end

  assign instruction   = imem[pc_current[7:0]];
  assign opcode        = opcode_e'(instruction[15:12]);
  assign src           = instruction[11:9];
  assign dest          = instruction[8:6];
  assign imm_or_fn     = instruction[5:0];
  assign sign_ext_imm  = {{10{imm_or_fn[5]}}, imm_or_fn};
  assign branch_offset = sign_ext_imm;
  assign write_reg     = dest;
  assign pc_plus1      = pc_current + 16'd1;

  assign read_data1 = (src == 3'd0) ? 16'h0000 : rf_q[src];
  assign read_data2 = (dest == 3'd0) ? 16'h0000 : rf_q[dest];

  // Decode
  always_comb begin
    alu_src   = 1'b0;
    alu_op    = AluAdd;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_next   = pc_plus1;
    case (opcode)
      OpRtype: begin
        alu_op    = alu_op_e'(imm_or_fn[2:0]);
        reg_write = 1'b1;
      end
      OpAddi: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OpLw: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OpSw: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OpBeq: begin
        if (read_data1 == read_data2) pc_next = pc_plus1 + branch_offset;
      end
      OpBne: begin
        if (read_data1 != read_data2) pc_next = pc_plus1 + branch_offset;
      end
      OpJmp: pc_next = {pc_current[15:12], instruction[11:0]};
      OpAndi: begin
        alu_src   = 1'b1;
        alu_op    = AluAnd;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_src_mux_out = alu_src ? sign_ext_imm : read_data2;

  always_comb begin
    alu_result = '0;
    unique case (alu_op)
      AluAdd: alu_result = read_data1 + alu_src_mux_out;
      AluSub: alu_result = read_data1 - alu_src_mux_out;
      AluAnd: alu_result = read_data1 & alu_src_mux_out;
      AluOr:  alu_result = read_data1 | alu_src_mux_out;
      AluXor: alu_result = read_data1 ^ alu_src_mux_out;
      AluSll: alu_result = read_data1 << alu_src_mux_out[3:0];
      AluSrl: alu_result = read_data1 >> alu_src_mux_out[3:0];
      AluSlt: alu_result = {15'd0, $signed(read_data1) < $signed(alu_src_mux_out)};
    endcase
  end

  assign mem_read_data = dmem[alu_result[7:0]];
  assign write_data    = (opcode == OpLw) ? mem_read_data : alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_current <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      pc_current <= pc_next;
      if (reg_write && (write_reg != 3'd0)) rf_q[write_reg] <= write_data;
    end
  end

  // RAM survives reset; only the store itself is gated.
  always_ff @(posedge clk) begin
    if (!reset && mem_write) dmem[alu_result[7:0]] <= read_data2;
  end

endmodule

// File: tb/tb_processor_16b.sv
// Directed bench for processor_16b: loads small programs into the ROM and checks
// architectural state and key internal nets against hand-computed values.
module tb_processor_16b;

  logic clk;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  processor_16b #(
    .IMEM_INIT("")
  ) dut (
    .clk  (clk),
    .reset(reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.imem[i] = 16'h0000;
    dut.imem[0]     = 16'h1045; // ADDI R1,R0,5
    dut.imem[1]     = 16'h10BD; // ADDI R2,R0,-3
    dut.imem[2]     = 16'h0280; // ADD  R2 <= R1 + R2
    dut.imem[3]     = 16'h3044; // SW   R1 -> [R0+4]
    dut.imem[4]     = 16'h20C4; // LW   R3 <- [R0+4]
    dut.imem[5]     = 16'h1007; // ADDI R0,R0,7
    dut.imem[6]     = 16'h5005; // BNE  R0,R0,+5 (not taken)
    dut.imem[7]     = 16'h6010; // JMP  0x010
    dut.imem[8'h10] = 16'h403F; // BEQ  R0,R0,-1 (self loop)
  endtask

  logic [15:0] fn_exp [8];

  initial begin
    fn_exp[0] = 16'h0002; // ADD
    fn_exp[1] = 16'h0008; // SUB
    fn_exp[2] = 16'h0005; // AND
    fn_exp[3] = 16'hFFFD; // OR
    fn_exp[4] = 16'hFFF8; // XOR
    fn_exp[5] = 16'hA000; // SLL by 13
    fn_exp[6] = 16'h0000; // SRL by 13
    fn_exp[7] = 16'h0000; // SLT signed: 5 < -3 false

    reset = 1'b1;
    load_prog();
    repeat (5) @(negedge clk);
    check("reset_pc", dut.pc_current, 16'h0000);
    check("reset_rd1", dut.read_data1, 16'h0000);
    check("reset_rd2", dut.read_data2, 16'h0000);
    reset = 1'b0;
    check("pc0_instr", dut.instruction, 16'h1045);
    check("pc0_wdata", dut.write_data, 16'h0005);

    @(negedge clk);
    check("pc1", dut.pc_current, 16'h0001);
    check("addi_r1", dut.rf_q[1], 16'h0005);
    check("sext_neg", dut.sign_ext_imm, 16'hFFFD);
    @(negedge clk);
    check("pc2", dut.pc_current, 16'h0002);
    check("addi_r2", dut.rf_q[2], 16'hFFFD);
    check("add_alu", dut.alu_result, 16'h0002);
    @(negedge clk);
    check("pc3", dut.pc_current, 16'h0003);
    check("add_r2", dut.rf_q[2], 16'h0002);
    check("sw_alu_src", {15'd0, dut.alu_src}, 16'h0001);
    check("sw_addr", dut.alu_result, 16'h0004);
    @(negedge clk);
    check("pc4", dut.pc_current, 16'h0004);
    check("sw_mem", dut.dmem[4], 16'h0005);
    check("lw_write_reg", {13'd0, dut.write_reg}, 16'h0003);
    check("lw_wdata", dut.write_data, 16'h0005);
    @(negedge clk);
    check("lw_r3", dut.rf_q[3], 16'h0005);
    @(negedge clk);
    check("pc6", dut.pc_current, 16'h0006);
    check("r0_reads_zero", dut.read_data1, 16'h0000);
    @(negedge clk);
    check("bne_not_taken", dut.pc_current, 16'h0007);
    @(negedge clk);
    check("jmp_target", dut.pc_current, 16'h0010);
    repeat (2) @(negedge clk);
    check("beq_self_loop", dut.pc_current, 16'h0010);

    // R-type function sweep on R1=5, R2=0xFFFD
    for (int f = 0; f < 8; f++) begin
      reset = 1'b1;
      dut.imem[2] = 16'h0280 | 16'(f);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("rtype_fn%0d", f), dut.rf_q[2], fn_exp[f]);
    end
    dut.imem[2] = 16'h0280;

    // Reset landing on the SW cycle must suppress the store
    dut.dmem[4] = 16'h0BAD;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_sw_pc", dut.pc_current, 16'h0003);
    reset = 1'b1;
    @(negedge clk);
    check("sw_reset_pc", dut.pc_current, 16'h0000);
    check("sw_suppressed", dut.dmem[4], 16'h0BAD);
    check("sw_reset_r1", dut.rf_q[1], 16'h0000);

    // Reset asserted at PC 6 clears registers and restarts at 0
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rerun_pc6", dut.pc_current, 16'h0006);
    check("rerun_r3", dut.rf_q[3], 16'h0005);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_pc", dut.pc_current, 16'h0000);
    for (int r = 1; r < 8; r++) begin
      check($sformatf("mid_reset_r%0d", r), dut.rf_q[3'(r)], 16'h0000);
    end
    reset = 1'b0;
    @(negedge clk);
    check("restart_pc1", dut.pc_current, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
